// File: rtl/axis_to_vector.sv
// Gathers VEC_BYTES/AXIS_BYTES stream beats into one parallel vector behind a valid/ready handshake.
// Checks frame length against tlast and resynchronises on the next tlast after a malformed frame.
module axis_to_vector #(
    parameter int unsigned VEC_BYTES     = 4,
    parameter int unsigned AXIS_BYTES    = 1,
    parameter bit          MSB_FIRST     = 1'b0,
    parameter bit          REQUIRE_TLAST = 1'b1
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic                    axis_tlast,
    input  logic [AXIS_BYTES*8-1:0] axis_tdata,
    output logic [VEC_BYTES*8-1:0]  vec,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    frame_err,
    output logic [7:0]              err_count
);
    localparam int unsigned N  = VEC_BYTES / AXIS_BYTES;
    localparam int unsigned DW = AXIS_BYTES * 8;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    generate
        if (AXIS_BYTES == 0 || VEC_BYTES == 0 || (VEC_BYTES % AXIS_BYTES) != 0) begin : g_bad_cfg
            $error("axis_to_vector: AXIS_BYTES must divide VEC_BYTES");
        end
    endgenerate

    typedef enum logic [1:0] {StFill, StHold, StDrain} state_e;

    state_e                 state_q;
    logic [CW-1:0]          ctr_q;
    logic [VEC_BYTES*8-1:0] vec_q;
    logic                   vec_valid_q;
    logic                   frame_err_q;
    logic [7:0]             err_count_q;

    logic                   accept;
    logic                   take_beat;
    logic                   is_last;
    logic [CW-1:0]          slot;
    logic [7:0]             err_count_inc;

    always_comb begin
        axis_tready = 1'b0;
        if (sresetn) begin
            case (state_q)
                StFill, StDrain: axis_tready = 1'b1;
                StHold:          axis_tready = vec_ready;
                default:         axis_tready = 1'b0;
            endcase
        end
    end

    assign accept        = axis_tvalid & axis_tready;
    // ctr is already 0 in HOLD, so a beat taken on release is simply beat 0 of the next frame.
    assign take_beat     = accept & (state_q != StDrain);
    assign is_last       = (ctr_q == LAST_IDX);
    assign slot          = MSB_FIRST ? (LAST_IDX - ctr_q) : ctr_q;
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q     <= StFill;
            ctr_q       <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            frame_err_q <= 1'b0;

            if (state_q == StHold && vec_ready) begin
                vec_valid_q <= 1'b0;
                state_q     <= StFill;
            end

            if (state_q == StDrain && accept && axis_tlast) begin
                state_q <= StFill;
            end

            // Later assignments override the HOLD release above when a new frame completes at once.
            if (take_beat) begin
                vec_q[slot*DW +: DW] <= axis_tdata;
                if (is_last) begin
                    ctr_q <= '0;
                    if (axis_tlast || !REQUIRE_TLAST) begin
                        state_q     <= StHold;
                        vec_valid_q <= 1'b1;
                    end else begin
                        state_q     <= StDrain;
                        frame_err_q <= 1'b1;
                        err_count_q <= err_count_inc;
                    end
                end else if (REQUIRE_TLAST && axis_tlast) begin
                    ctr_q       <= '0;
                    frame_err_q <= 1'b1;
                    err_count_q <= err_count_inc;
                end else begin
                    ctr_q <= ctr_q + 1'b1;
                end
            end
        end
    end

    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_axis_to_vector.sv
// Drives an LSB-first and an MSB-first instance with identical streams and compares both against a
// frame-level queue model, a table of hand-computed vectors and a few directed corner sequences.
module tb_axis_to_vector;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        axis_tvalid = 1'b0;
    logic        axis_tlast = 1'b0;
    logic [7:0]  axis_tdata = 8'h00;
    logic        vec_ready = 1'b0;

    logic        tready_l, tready_m;
    logic [31:0] vec_l, vec_m;
    logic        valid_l, valid_m;
    logic        err_l, err_m;
    logic [7:0]  cnt_l, cnt_m;

    always #5 clk = ~clk;

    axis_to_vector #(
        .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b0), .REQUIRE_TLAST(1'b1)
    ) dut_lsb (
        .clk(clk), .sresetn(sresetn), .axis_tvalid(axis_tvalid), .axis_tready(tready_l),
        .axis_tlast(axis_tlast), .axis_tdata(axis_tdata), .vec(vec_l), .vec_valid(valid_l),
        .vec_ready(vec_ready), .frame_err(err_l), .err_count(cnt_l)
    );

    axis_to_vector #(
        .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b1), .REQUIRE_TLAST(1'b1)
    ) dut_msb (
        .clk(clk), .sresetn(sresetn), .axis_tvalid(axis_tvalid), .axis_tready(tready_m),
        .axis_tlast(axis_tlast), .axis_tdata(axis_tdata), .vec(vec_m), .vec_valid(valid_m),
        .vec_ready(vec_ready), .frame_err(err_m), .err_count(cnt_m)
    );

    // Reference model: beats of the frame in progress, plus what the consumer should currently see.
    logic [7:0]  q[$];
    bit          m_drain, m_valid, m_err;
    int          m_cnt;
    logic [31:0] m_vec_l, m_vec_m;

    int   n_vec = 0;
    int   n_bad = 0;
    logic last_tready;

    typedef struct {
        logic        tvalid;
        logic        tlast;
        logic [7:0]  data;
        logic        vready;
        logic        exp_rdy;
        logic        exp_valid;
        logic [31:0] exp_l;
        logic [31:0] exp_m;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } row_t;

    row_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_err();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic r);
        axis_tvalid = v;
        axis_tlast  = l;
        axis_tdata  = d;
        vec_ready   = r;
    endtask

    // One clock: check tready before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        bit exp_rdy, acc;
        #1;
        exp_rdy = sresetn && (!m_valid || vec_ready);
        chk("tready_lsb", tready_l, exp_rdy);
        chk("tready_msb", tready_m, exp_rdy);
        last_tready = tready_l;
        acc = axis_tvalid && exp_rdy;
        @(posedge clk);
        m_err = 1'b0;
        if (!sresetn) begin
            q.delete();
            m_drain = 0;
            m_valid = 0;
            m_cnt   = 0;
        end else begin
            if (m_valid && vec_ready) m_valid = 0;
            if (acc) begin
                if (m_drain) begin
                    if (axis_tlast) m_drain = 0;
                end else begin
                    q.push_back(axis_tdata);
                    if (q.size() == N) begin
                        for (int k = 0; k < N; k++) begin
                            m_vec_l[8*k +: 8]       = q[k];
                            m_vec_m[8*(N-1-k) +: 8] = q[k];
                        end
                        if (axis_tlast) m_valid = 1;
                        else begin
                            flag_err();
                            m_drain = 1;
                        end
                        q.delete();
                    end else if (axis_tlast) begin
                        flag_err();
                        q.delete();
                    end
                end
            end
        end
        #1;
        chk("valid_lsb", valid_l, m_valid);
        chk("valid_msb", valid_m, m_valid);
        chk("err_lsb", err_l, m_err);
        chk("err_msb", err_m, m_err);
        chk("cnt_lsb", cnt_l, m_cnt);
        chk("cnt_msb", cnt_m, m_cnt);
        if (m_valid) begin
            chk("vec_lsb", vec_l, m_vec_l);
            chk("vec_msb", vec_m, m_vec_m);
        end
    endtask

    initial begin
        int nvalid, nerr, drops;

        tbl[0]  = '{1, 0, 8'h11, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 8'h22, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 8'h33, 1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 8'h44, 1, 1, 1, 32'h44332211, 32'h11223344, 0, 0};
        tbl[4]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 8'h01, 1, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 8'h02, 1, 1, 0, 0, 0, 1, 1};
        tbl[7]  = '{1, 0, 8'hAA, 1, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 8'hBB, 1, 1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 8'hCC, 1, 1, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 8'hDD, 1, 1, 1, 32'hDDCCBBAA, 32'hAABBCCDD, 0, 1};
        tbl[11] = '{1, 0, 8'hEE, 0, 0, 1, 32'hDDCCBBAA, 32'hAABBCCDD, 0, 1};
        tbl[12] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1};

        // Reset, with a beat offered to show tready is gated low.
        sresetn = 1'b0;
        drive(1, 0, 8'h5A, 1);
        cycle();
        cycle();
        chk("rst_vec_lsb", vec_l, 32'h0);
        chk("rst_vec_msb", vec_m, 32'h0);
        chk("rst_tready", last_tready, 1'b0);
        sresetn = 1'b1;

        // Basic LSB/MSB assembly, early tlast and recovery.
        foreach (tbl[i]) begin
            drive(tbl[i].tvalid, tbl[i].tlast, tbl[i].data, tbl[i].vready);
            cycle();
            chk("tbl_tready", last_tready, tbl[i].exp_rdy);
            chk("tbl_valid", valid_l, tbl[i].exp_valid);
            chk("tbl_err", err_l, tbl[i].exp_err);
            chk("tbl_cnt", cnt_m, tbl[i].exp_cnt);
            if (tbl[i].exp_valid) begin
                chk("tbl_vec_lsb", vec_l, tbl[i].exp_l);
                chk("tbl_vec_msb", vec_m, tbl[i].exp_m);
            end
        end

        // Consumer stalls for 5 cycles while a beat waits: vector stable, tready low.
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 3, 8'h11 * (i + 1), 0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 8'h77, 0);
            cycle();
            chk("stall_tready", last_tready, 1'b0);
            chk("stall_vec_msb", vec_m, 32'h11223344);
            chk("stall_valid", valid_m, 1'b1);
        end
        drive(0, 0, 8'h00, 1);
        cycle();

        // Three back-to-back frames at full throughput.
        nvalid = 0;
        drops  = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, (i % 4) == 3, 8'(8'h30 + i), 1);
            cycle();
            if (!last_tready) drops++;
            if (valid_l) nvalid++;
        end
        chk("b2b_vectors", nvalid, 3);
        chk("b2b_tready_drops", drops, 0);
        drive(0, 0, 8'h00, 1);
        cycle();

        // Missing tlast: one error, extra beats drained, then a clean frame.
        nvalid = 0;
        nerr   = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, i == 5, 8'(8'hC0 + i), 1);
            cycle();
            if (valid_l) nvalid++;
            if (err_l) nerr++;
        end
        chk("drain_errs", nerr, 1);
        chk("drain_valids", nvalid, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 3, 8'(5 + i), 1);
            cycle();
        end
        chk("post_drain_vec", vec_l, 32'h08070605);
        drive(0, 0, 8'h00, 1);
        cycle();

        // Reset mid-frame, then a full frame.
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 8'hF0, 1);
            cycle();
        end
        sresetn = 1'b0;
        cycle();
        chk("midrst_tready", last_tready, 1'b0);
        chk("midrst_cnt", cnt_l, 8'd0);
        sresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 3, 8'(i + 1), 1);
            cycle();
        end
        chk("midrst_vec_lsb", vec_l, 32'h04030201);
        chk("midrst_vec_msb", vec_m, 32'h01020304);

        // 300 one-beat frames saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 8'(i), 1);
            cycle();
        end
        chk("sat_cnt", cnt_l, 8'd255);
        drive(1, 1, 8'h99, 1);
        cycle();
        chk("sat_pulse", err_l, 1'b1);
        chk("sat_hold", cnt_m, 8'd255);

        // Random traffic with occasional resets; tlast usually placed correctly.
        for (int i = 0; i < 3000; i++) begin
            sresetn     = ($urandom_range(0, 299) != 0);
            axis_tvalid = ($urandom_range(0, 3) != 0);
            axis_tlast  = ($urandom_range(0, 9) < 8) ? (q.size() == N - 1) : 1'($urandom_range(0, 1));
            axis_tdata  = 8'($urandom);
            vec_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
